// File: rtl/console_pkg.sv
// Shared constants, control codes, FSM state type and address helpers for the
// text console.
package console_pkg;

  localparam int COLS  = 64;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] BLANK        = 8'h20;
  localparam logic [7:0] CURSOR_GLYPH = 8'h5F;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  localparam logic [4:0] LAST_ROW = 5'd29;
  localparam logic [5:0] LAST_COL = 6'd63;

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_e;

  // Row increment modulo 30; 29 wraps to 0 explicitly rather than by overflow.
  function automatic logic [4:0] row_inc(input logic [4:0] r);
    return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
  endfunction

  // Logical (row, col) to physical cell index through the circular top pointer.
  function automatic logic [10:0] phys_addr(input logic [4:0] lrow,
                                            input logic [4:0] top,
                                            input logic [5:0] col);
    logic [5:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= 6'd30) sum = sum - 6'd30;
    return {sum[4:0], col};
  endfunction

endpackage

// File: rtl/console_ram.sv
// 1920x8 simple dual-port screen memory: one synchronous write port and one
// synchronous read port on pclk; a same-cell read during a write returns old data.
module console_ram
  import console_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic        we,
  input  logic [10:0] waddr,
  input  logic [7:0]  wdata,
  input  logic [10:0] raddr,
  output logic [7:0]  rdata
);

  logic [7:0] mem [CELLS];

  // NOTE: the storage array is never reset (the console clears it by sweeping);
  // only the read register has a reset value.
  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge pclk) begin
    if (rst) rdata <= 8'h00;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_console.sv
// 64x30 character-cell terminal buffer with cursor, wrap, control codes and
// circular-pointer scrolling. Optional cursor blink: define CONSOLE_CURSOR_EN.
module text_console
  import console_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [11:0] rdaddr,
  output logic [7:0]  ascii_code,
  output logic [4:0]  cursor_row,
  output logic [5:0]  cursor_col
);

  state_e      state;
  logic [4:0]  top;
  logic [4:0]  clr_row;
  logic [10:0] clr_cnt;
  logic [4:0]  cur_row;
  logic [5:0]  cur_col;

  logic        accept;
  logic        is_print;
  logic        bs_move;
  logic [4:0]  bs_row;
  logic [5:0]  bs_col;

  logic        we;
  logic [10:0] waddr;
  logic [7:0]  wdata;
  logic        rd_oob;
  logic [10:0] raddr;
  logic [7:0]  ram_q;
  logic        cursor_hit;
  logic        oob_q;
  logic        hit_q;

  assign char_ready = (state == IDLE);
  assign accept     = char_valid && char_ready;
  assign is_print   = (char_in >= 8'h20) && (char_in != 8'h7F);
  assign bs_move    = (cur_row != 5'd0) || (cur_col != 6'd0);
  assign cursor_row = cur_row;
  assign cursor_col = cur_col;

  // Backspace target: the column wraps 0 -> 63 naturally in 6 bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    bs_row = cur_row;
    bs_col = cur_col - 6'd1;
    if (cur_col == 6'd0 && cur_row != 5'd0) bs_row = cur_row - 5'd1;
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = BLANK;
    case (state)
      CLR_ALL: begin
        we    = 1'b1;
        waddr = clr_cnt;
      end
      CLR_LINE: begin
        we    = 1'b1;
        waddr = {clr_row, clr_cnt[5:0]};
      end
      default: begin
        if (accept) begin
          if (is_print) begin
            we    = 1'b1;
            waddr = phys_addr(cur_row, top, cur_col);
            wdata = char_in;
          end else if (char_in == BS && bs_move) begin
            we    = 1'b1;
            waddr = phys_addr(bs_row, top, bs_col);
          end
        end
      end
    endcase
    if (rst) we = 1'b0;
  end

  always_ff @(posedge pclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= CLR_ALL;
      clr_cnt <= '0;
      clr_row <= '0;
      top     <= '0;
      cur_row <= '0;
      cur_col <= '0;
    end else begin
      case (state)
        CLR_ALL: begin
          if (clr_cnt == 11'(CELLS - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 11'd1;
          end
        end
        CLR_LINE: begin
          if (clr_cnt[5:0] == LAST_COL) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 11'd1;
          end
        end
        default: begin
          if (accept) begin
            if (is_print || char_in == LF) begin
              if (is_print && cur_col != LAST_COL) begin
                cur_col <= cur_col + 6'd1;
              end else begin
                cur_col <= '0;
                // Advancing past the bottom scrolls: the old top row becomes the new bottom.
                if (cur_row == LAST_ROW) begin
                  top     <= row_inc(top);
                  clr_row <= top;
                  clr_cnt <= '0;
                  state   <= CLR_LINE;
                end else begin
                  cur_row <= cur_row + 5'd1;
                end
              end
            end else if (char_in == CR) begin
              cur_col <= '0;
            end else if (char_in == BS) begin
              if (bs_move) begin
                cur_row <= bs_row;
                cur_col <= bs_col;
              end
            end else if (char_in == FF) begin
              state   <= CLR_ALL;
              clr_cnt <= '0;
              top     <= '0;
              cur_row <= '0;
              cur_col <= '0;
            end
          end
        end
      endcase
    end
  end

  assign rd_oob = (rdaddr[11:6] >= 6'd30);
  assign raddr  = rd_oob ? '0 : phys_addr(rdaddr[10:6], top, rdaddr[5:0]);

`ifdef CONSOLE_CURSOR_EN
  logic [31:0] blink_cnt;
  logic        blink_phase;

  always_ff @(posedge pclk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  assign cursor_hit = blink_phase && (rdaddr == {1'b0, cur_row, cur_col});
`else
  assign cursor_hit = 1'b0;
`endif

  console_ram u_ram (
    .pclk  (pclk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Override flags are registered alongside the RAM read so all sources share one cycle of latency.
  always_ff @(posedge pclk) begin
    if (rst) begin
      oob_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      oob_q <= rd_oob;
      hit_q <= cursor_hit;
    end
  end

  assign ascii_code = oob_q ? BLANK : (hit_q ? CURSOR_GLYPH : ram_q);

endmodule

// File: doc/text_console.md
# text_console

Character-cell terminal buffer that sits directly upstream of the VGA text renderer. It accepts a stream of ASCII bytes from the CPU/keyboard path and maintains a 64×30 screen image with cursor, line wrap, control characters and hardware scrolling. The renderer reads characters through a synchronous lookup port, `rdaddr` in and `ascii_code` out. Scrolling uses a circular top-row pointer, so only one 64-cell line is cleared per scroll.

## Interface
Parameters:
- `BLINK_CYCLES`, default 12_500_000: half-period of the cursor blink in `pclk` cycles. Used only with `CONSOLE_CURSOR_EN`.

Ports:
- `pclk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `char_in`  in  8  ASCII byte to append.
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  block can accept a byte this cycle.
- `rdaddr`  in  12  logical cell address from the renderer: row×64 + col.
- `ascii_code`  out  8  character at `rdaddr`, registered.
- `cursor_row`  out  5  current cursor row, 0–29.
- `cursor_col`  out  6  current cursor column, 0–63.

## Operation
- Storage: 1920 bytes. Physical address = ((logical_row + top) mod 30)×64 + col.
- State machine: IDLE, CLR_LINE, CLR_ALL.
  - `char_ready` = (state == IDLE).
  - A byte is accepted on a cycle where `char_valid && char_ready`.
- Printable bytes (0x20–0x7E, and 0x80–0xFF passed through):
  - Write the byte at the cursor, then col+1.
  - At col 63 the cursor wraps to col 0, row+1.
- 0x0A (LF): col←0, row+1.
- 0x0D (CR): col←0; the row is unchanged.
- 0x08 (BS):
  - col>0: col−1.
  - col=0 and row>0: row−1, col←63.
  - col=0 and row=0: no-op.
  - The cell at the new position is then written with 0x20.
- 0x0C (FF): enter CLR_ALL, then cursor←(0,0) and top←0.
- Other bytes 0x00–0x1F and 0x7F: accepted and ignored.
- Row advance from row 29 (wrap or LF):
  - Cursor row stays 29.
  - top←(top+1) mod 30.
  - Enter CLR_LINE on the new bottom physical row, which is the old top.
- CLR_LINE: writes 0x20 to 64 cells, one per cycle, then returns to IDLE.
- CLR_ALL: writes 0x20 to all 1920 cells, one per cycle, then returns to IDLE.
- Counter arithmetic:
  - Row arithmetic is modulo 30. The `top`+1 increment wraps 29→0 explicitly, not by 5-bit overflow.
  - The column counter is 6-bit and wraps naturally.
- Reads:
  - `rdaddr` row field (bits 11:6) ≥30 returns 0x20.
  - The read port is independent of writes and never stalls.

## Timing
- Reset:
  - state←CLR_ALL, top←0, cursor (0,0).
  - `char_ready`=0 for exactly 1920 cycles after `rst` deasserts, then 1.
  - `ascii_code` resets to 0x00.
- Read latency: 1 cycle. `ascii_code` at edge N+1 reflects `rdaddr` sampled at edge N.
- Same-cycle write and read of the same physical cell: the read returns the old data.
- Accepted printable byte:
  - The cell is written at the accepting edge.
  - The cursor updates at the same edge.
  - The new value is visible to a read issued on the next cycle.
- Scroll: the accepting edge updates top; CLR_LINE occupies the next 64 cycles with `char_ready`=0.
- `rst` asserted mid-CLR_LINE or mid-CLR_ALL aborts the clear and restarts the reset CLR_ALL sequence.
- `char_valid` while `char_ready`=0: the byte is not consumed. The producer must hold it.

## Configuration
- `CONSOLE_CURSOR_EN` defined:
  - A blink counter toggles a phase bit every `BLINK_CYCLES`.
  - While the phase bit is 1, a read whose logical address equals the cursor returns 0x5F ('_') instead of the stored byte.
  - The phase bit resets to 0.
- Undefined: no blink counter, and reads always return stored data.

## Structure
- Shared package `console_pkg`:
  - Constants COLS=64, ROWS=30, CELLS=1920, BLANK=8'h20, CURSOR_GLYPH=8'h5F.
  - Control codes LF, CR, BS, FF.
  - The state enum {IDLE, CLR_LINE, CLR_ALL}.
- One sub-module `console_ram`: 1920×8 simple dual-port RAM, one synchronous write port and one synchronous read port, both on `pclk`.

## Test plan
- Reset, wait 1920 cycles → `char_ready` rises on cycle 1920; reading all 1920 addresses returns 0x20.
- Send "AB", 0x0D, "C" → cell 0 = 'C', cell 1 = 'B', cursor (0,1).
- Send 65 'x' → row 0 all 'x', cell 64 = 'x', cursor (1,1).
- Fill rows 0–29 with row-index glyphs ('0'+row), then send LF at row 29 →
  - `char_ready` low for 64 cycles.
  - Logical row 0 reads '1', logical row 28 reads the former row-29 glyph.
  - Logical row 29 reads 0x20.
- BS at (1,0) → cursor (0,63) and cell 63 = 0x20. BS at (0,0) → no change.
- With `CONSOLE_CURSOR_EN`, `BLINK_CYCLES`=4, cursor at (2,5) → reading address 133 alternates 0x5F and stored data every 4 cycles.
